// File: rtl/crc_pkg.sv
// Shared constants for the streaming CRC engine: common generator polynomials
// (x^CRC_W term implied) and an elaboration-time parameter legality check.
package crc_pkg;

    localparam logic [4:0]  CRC5_USB    = 5'h05;
    localparam logic [7:0]  CRC8        = 8'h07;
    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [31:0] CRC32       = 32'h04C11DB7;

    function automatic bit crc_params_ok(input int data_w, input int crc_w);
        return (data_w >= 1) && (data_w <= 64) && (crc_w >= 2) && (crc_w <= 32);
    endfunction

endpackage

// File: rtl/crc_stream_if.sv
// Beat-in / checksum-out stream bundle for crc_stream; the slave modport is the
// engine side, the master modport is the producer/consumer side.
interface crc_stream_if #(
    parameter int DATA_W = 4,
    parameter int CRC_W  = 5
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_first;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [CRC_W-1:0]  out_crc;

    modport master (
        output in_valid, in_data, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_crc
    );

    modport slave (
        input  in_valid, in_data, in_first, in_last, out_ready,
        output in_ready, out_valid, out_crc
    );

endinterface

// File: rtl/crc_next.sv
// Combinational fold of one DATA_W-bit beat into a CRC_W-bit state, MSB first.
// With the default parameters and a zero seed this is the legacy 4/5-bit generator.
module crc_next #(
    parameter int               DATA_W = 4,
    parameter int               CRC_W  = 5,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(5'h05)
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] crc_v;
    logic             fb;

    always_comb begin
        crc_v = crc_in;
        fb    = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb    = crc_v[CRC_W-1] ^ data[i];
            crc_v = {crc_v[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: accumulates multi-beat messages and presents each final
// checksum on a registered output held until the consumer takes it.
module crc_stream
    import crc_pkg::*;
#(
    parameter int               DATA_W  = 4,
    parameter int               CRC_W   = 5,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC5_USB),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
    input logic         clk,
    input logic         rst_n,
    crc_stream_if.slave s
);

    if (!crc_params_ok(DATA_W, CRC_W)) begin : g_bad_params
        $error("crc_stream: DATA_W must be 1..64 and CRC_W 2..32");
    end

    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] out_crc_q, out_crc_d;
    logic             out_valid_q, out_valid_d;
    logic [CRC_W-1:0] seed;
    logic [CRC_W-1:0] folded;
    logic             accept;

    // A result slot frees up in the same cycle the consumer takes it.
    assign s.in_ready  = !out_valid_q || s.out_ready;
    assign accept      = s.in_valid && s.in_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_crc   = out_crc_q;

    // in_first discards whatever message was open and reseeds.
    assign seed = s.in_first ? INIT : crc_q;

    crc_next #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_fold (
        .crc_in  (seed),
        .data    (s.in_data),
        .crc_out (folded)
    );

    always_comb begin
        crc_d       = crc_q;
        out_crc_d   = out_crc_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && s.out_ready) begin
            out_valid_d = 1'b0;
        end
        // A last beat accepted on the pop edge keeps out_valid high with the new value.
        if (accept) begin
            if (s.in_last) begin
                out_crc_d   = folded ^ XOR_OUT;
                out_valid_d = 1'b1;
                crc_d       = INIT;
            end else begin
                crc_d = folded;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q       <= INIT;
            out_crc_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            crc_q       <= crc_d;
            out_crc_q   <= out_crc_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_crc_stream.sv
// Randomized and directed bench for crc_stream; expected checksums come from
// polynomial long division over the whole message, not from a per-bit fold.
module tb_crc_stream;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc_stream_if #(.DATA_W(4),  .CRC_W(5))  ifc();
    crc_stream_if #(.DATA_W(8),  .CRC_W(16)) ifc16();
    crc_stream_if #(.DATA_W(8),  .CRC_W(32)) ifc32();

    crc_stream dut (.clk(clk), .rst_n(rst_n), .s(ifc));

    crc_stream #(.DATA_W(8), .CRC_W(16), .POLY(CRC16_CCITT), .INIT(16'hFFFF),
                 .XOR_OUT(16'h0000)) dut16 (.clk(clk), .rst_n(rst_n), .s(ifc16));

    crc_stream #(.DATA_W(8), .CRC_W(32), .POLY(CRC32), .INIT(32'hFFFFFFFF),
                 .XOR_OUT(32'hFFFFFFFF)) dut32 (.clk(clk), .rst_n(rst_n), .s(ifc32));

    int n_cmp = 0;
    int n_bad = 0;
    int n_beats = 0;

    // Model state for the default instance
    bit         m_valid = 1'b0;
    logic [4:0] m_crc = '0;
    bit         mbits[$];

    // Remainder of (init*x^L + M(x)*x^w) mod (x^w + poly), then XOR_OUT.
    function automatic logic [31:0] ref_crc(input bit msg[$], input int w,
                                            input logic [31:0] poly,
                                            input logic [31:0] init,
                                            input logic [31:0] xo);
        bit          a[];
        int          len;
        logic [31:0] r;
        len = msg.size();
        a = new[len + w];
        foreach (a[i]) a[i] = 1'b0;
        for (int j = 0; j < len; j++) a[w + len - 1 - j] = msg[j];
        for (int k = 0; k < w; k++) a[len + k] ^= init[k];
        for (int e = len + w - 1; e >= w; e--) begin
            if (a[e]) begin
                a[e] = 1'b0;
                for (int k = 0; k < w; k++) a[e - w + k] ^= poly[k];
            end
        end
        r = '0;
        for (int k = 0; k < w; k++) r[k] = a[k];
        return r ^ xo;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pin(input string name, input logic [31:0] v, input int nbits,
                       input logic [31:0] exp);
        bit q[$];
        for (int b = nbits - 1; b >= 0; b--) q.push_back(v[b]);
        chk(name, ref_crc(q, 5, 32'h05, 32'h0, 32'h0), exp);
    endtask

    // One clock on the default instance; called 1 time unit after a rising edge.
    task automatic step(input bit v, input logic [3:0] d, input bit f, input bit l,
                        input bit r);
        bit          acc;
        logic [31:0] res;
        ifc.in_valid  = v;
        ifc.in_data   = d;
        ifc.in_first  = f;
        ifc.in_last   = l;
        ifc.out_ready = r;
        #1;
        chk("in_ready", {31'b0, ifc.in_ready}, {31'b0, (!m_valid || r)});
        acc = v && (!m_valid || r);
        @(posedge clk);
        if (m_valid && r) m_valid = 1'b0;
        if (acc) begin
            n_beats++;
            if (f) mbits.delete();
            for (int b = 3; b >= 0; b--) mbits.push_back(d[b]);
            if (l) begin
                res     = ref_crc(mbits, 5, 32'h05, 32'h0, 32'h0);
                m_crc   = res[4:0];
                m_valid = 1'b1;
                mbits.delete();
            end
        end
        #1;
        chk("out_valid", {31'b0, ifc.out_valid}, {31'b0, m_valid});
        if (m_valid) chk("out_crc", {27'b0, ifc.out_crc}, {27'b0, m_crc});
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'h0);
        chk("rst_out_crc",   {27'b0, ifc.out_crc},   32'h0);
        chk("rst_in_ready",  {31'b0, ifc.in_ready},  32'h1);
        m_valid = 1'b0;
        m_crc   = '0;
        mbits.delete();
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = x[7 - i];
        return y;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[i] = x[31 - i];
        return y;
    endfunction

    logic [7:0] check_str [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    task automatic run_wide();
        bit          q16[$];
        bit          q32[$];
        logic [7:0]  rb;
        logic [31:0] res;
        for (int i = 0; i < 9; i++) begin
            rb = rev8(check_str[i]);
            ifc16.in_valid = 1'b1;
            ifc16.in_data  = check_str[i];
            ifc16.in_first = (i == 0);
            ifc16.in_last  = (i == 8);
            ifc32.in_valid = 1'b1;
            ifc32.in_data  = rb;
            ifc32.in_first = (i == 0);
            ifc32.in_last  = (i == 8);
            for (int b = 7; b >= 0; b--) begin
                q16.push_back(check_str[i][b]);
                q32.push_back(rb[b]);
            end
            @(posedge clk);
            #1;
        end
        ifc16.in_valid = 1'b0;
        ifc32.in_valid = 1'b0;
        chk("crc16_valid", {31'b0, ifc16.out_valid}, 32'h1);
        chk("crc16_check", {16'b0, ifc16.out_crc}, 32'h000029B1);
        res = ref_crc(q16, 16, 32'h1021, 32'hFFFF, 32'h0);
        chk("crc16_model", {16'b0, ifc16.out_crc}, res);
        chk("crc32_valid", {31'b0, ifc32.out_valid}, 32'h1);
        chk("crc32_check", rev32(ifc32.out_crc), 32'hCBF43926);
        res = ref_crc(q32, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("crc32_model", ifc32.out_crc, res);
    endtask

    initial begin
        ifc.in_valid = 1'b0;   ifc.in_data = '0;   ifc.in_first = 1'b0;
        ifc.in_last = 1'b0;    ifc.out_ready = 1'b1;
        ifc16.in_valid = 1'b0; ifc16.in_data = '0; ifc16.in_first = 1'b0;
        ifc16.in_last = 1'b0;  ifc16.out_ready = 1'b1;
        ifc32.in_valid = 1'b0; ifc32.in_data = '0; ifc32.in_first = 1'b0;
        ifc32.in_last = 1'b0;  ifc32.out_ready = 1'b1;

        // Pin the reference model to hand-computed values
        pin("model_1", 32'h1, 4, 32'h05);
        pin("model_8", 32'h8, 4, 32'h0D);
        pin("model_9", 32'h9, 4, 32'h08);
        pin("model_10", 32'h10, 8, 32'h1A);

        #3;
        chk("reset_out_valid", {31'b0, ifc.out_valid}, 32'h0);
        chk("reset_out_crc",   {27'b0, ifc.out_crc},   32'h0);
        chk("reset_in_ready",  {31'b0, ifc.in_ready},  32'h1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat messages
        step(1, 4'h1, 1, 1, 1); chk("single_1", {27'b0, ifc.out_crc}, 32'h05);
        step(1, 4'h8, 1, 1, 1); chk("single_8", {27'b0, ifc.out_crc}, 32'h0D);
        step(1, 4'h9, 1, 1, 1); chk("single_9", {27'b0, ifc.out_crc}, 32'h08);

        // Two-beat message, then a mid-message restart
        step(1, 4'h1, 1, 0, 1);
        step(1, 4'h0, 0, 1, 1); chk("two_beat", {27'b0, ifc.out_crc}, 32'h1A);
        step(1, 4'h1, 1, 0, 1);
        step(1, 4'h0, 0, 0, 1);
        step(1, 4'h1, 1, 1, 1); chk("restart", {27'b0, ifc.out_crc}, 32'h05);

        // Back-pressure with a last beat waiting
        step(1, 4'h1, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'h9, 1, 1, 0);
            chk("bp_in_ready", {31'b0, ifc.in_ready}, 32'h0);
            chk("bp_frozen", {27'b0, ifc.out_crc}, 32'h05);
        end
        step(1, 4'h9, 1, 1, 1);
        chk("bp_release_valid", {31'b0, ifc.out_valid}, 32'h1);
        chk("bp_release_crc", {27'b0, ifc.out_crc}, 32'h08);
        step(0, 4'h0, 0, 0, 1);

        // Reset mid-message and with a pending result
        step(1, 4'h8, 1, 0, 1);
        pulse_reset();
        step(1, 4'h1, 0, 1, 1); chk("post_reset_init", {27'b0, ifc.out_crc}, 32'h05);
        step(1, 4'h9, 1, 1, 0);
        pulse_reset();
        step(0, 4'h0, 0, 0, 1);

        run_wide();

        // Random stress
        for (int cyc = 0; cyc < 60000 && n_beats < 10000; cyc++) begin
            if (cyc == 7000) pulse_reset();
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) > 1);
        end
        chk("stress_beats_done", {31'b0, (n_beats >= 10000)}, 32'h1);
        step(0, 4'h0, 0, 0, 1);
        step(0, 4'h0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
